// File: rtl/serial_seq_pkg.sv
// Shared types, state encodings and defaults for the serial sequencer.
// Counter width helper sizes every counter to hold the largest terminal count.
package serial_seq_pkg;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_RESP_W  = 8;
  localparam int DEF_TIMEOUT = 16;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_START = 3'd1;
  localparam state_t ST_SHIFT = 3'd2;
  localparam state_t ST_WAIT  = 3'd3;
  localparam state_t ST_CAPT  = 3'd4;
  localparam state_t ST_DONE  = 3'd5;

  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/serial_seq_ctrl_if.sv
// Command and response handshake bundle between the front-end (master)
// and the serial sequencer (slave).
interface serial_seq_ctrl_if
  import serial_seq_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int RESP_W = DEF_RESP_W
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [DATA_W-1:0] cmd_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [RESP_W-1:0] rsp_data;
  logic              rsp_err;

  modport master (
    output cmd_valid, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_err
  );

endinterface

// File: rtl/serial_shreg.sv
// Generic left-shifting register: clear beats load beats shift.
// Bits enter at the LSB and leave from the MSB.
module serial_shreg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic [W-1:0] i_d,
  input  logic         i_shift,
  input  logic         i_sin,
  output logic         o_msb,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  // Shift register storage with clear/load/shift priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= {W{1'b0}};
    end else if (i_clr) begin
      r_q <= {W{1'b0}};
    end else if (i_load) begin
      r_q <= i_d;
    end else if (i_shift) begin
      r_q <= (r_q << 1'b1) | W'(i_sin);
    end else begin
      r_q <= r_q;
    end
  end

  assign o_msb = r_q[W-1];
  assign o_q   = r_q;

endmodule

// File: rtl/serial_seq_ctrl.sv
// Frames a parallel command as start pulse + MSB-first serial bits, then
// waits a bounded time for a start-bit-led serial response and returns it.
module serial_seq_ctrl
  import serial_seq_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int RESP_W  = DEF_RESP_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  serial_seq_ctrl_if.slave         bus,
  input  logic                     i_abort,
  output logic                     o_start,
  output logic                     o_din,
  input  logic                     i_dout,
  output logic                     o_busy
);

  localparam int CNT_W = cnt_width(DATA_W, RESP_W, TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CAPT_LAST  = CNT_W'(RESP_W - 1);

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_start;
  logic               r_din;
  logic               r_cmd_ready;
  logic               r_err;
  logic               w_accept;
  logic               w_abort;
  logic               w_timeout;
  logic               w_counting;
  logic               w_tx_msb;
  logic [DATA_W-1:0]  w_tx_q_unused;
  logic               w_rx_msb_unused;
  logic [RESP_W-1:0]  w_rx_q;

  assign w_accept   = (r_state == ST_IDLE) & bus.cmd_valid & r_cmd_ready;
  assign w_abort    = i_abort & (r_state != ST_IDLE);
  assign w_timeout  = (r_state == ST_WAIT) & ~i_dout & (r_cnt == WAIT_LAST) & ~w_abort;
  assign w_counting = (r_state == ST_SHIFT) | (r_state == ST_WAIT) | (r_state == ST_CAPT);

  // Next-state decode; abort overrides every other transition
  always_comb begin
    w_next = r_state;
    if (w_abort) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (w_accept) w_next = ST_START; else w_next = ST_IDLE;
        ST_START: w_next = ST_SHIFT;
        ST_SHIFT: if (r_cnt == SHIFT_LAST) w_next = ST_WAIT; else w_next = ST_SHIFT;
        ST_WAIT: begin
          if (i_dout)                  w_next = ST_CAPT;
          else if (r_cnt == WAIT_LAST) w_next = ST_DONE;
          else                         w_next = ST_WAIT;
        end
        ST_CAPT:  if (r_cnt == CAPT_LAST) w_next = ST_DONE; else w_next = ST_CAPT;
        ST_DONE:  if (bus.rsp_ready) w_next = ST_IDLE; else w_next = ST_DONE;
        default:  w_next = ST_IDLE;
      endcase
    end
  end

  // State, per-state counter and registered serial/handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= CNT_ZERO;
      r_start     <= 1'b0;
      r_din       <= 1'b0;
      r_cmd_ready <= 1'b1;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_next;
      // Counter restarts on every state entry, so it never wraps in-state
      if (w_counting && (w_next == r_state)) begin
        r_cnt <= r_cnt + CNT_ONE;
      end else begin
        r_cnt <= CNT_ZERO;
      end
      r_start     <= (w_next == ST_START);
      r_din       <= (w_next == ST_SHIFT) & w_tx_msb;
      r_cmd_ready <= (w_next == ST_IDLE);
      if (w_accept) begin
        r_err <= 1'b0;
      end else if (w_timeout) begin
        r_err <= 1'b1;
      end else begin
        r_err <= r_err;
      end
    end
  end

  serial_shreg #(.W(DATA_W)) u_tx (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (1'b0),
    .i_load  (w_accept),
    .i_d     (bus.cmd_data),
    .i_shift (w_next == ST_SHIFT),
    .i_sin   (1'b0),
    .o_msb   (w_tx_msb),
    .o_q     (w_tx_q_unused)
  );

  serial_shreg #(.W(RESP_W)) u_rx (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (w_accept),
    .i_load  (1'b0),
    .i_d     ({RESP_W{1'b0}}),
    .i_shift (r_state == ST_CAPT),
    .i_sin   (i_dout),
    .o_msb   (w_rx_msb_unused),
    .o_q     (w_rx_q)
  );

  assign o_start       = r_start;
  assign o_din         = r_din;
  assign o_busy        = (r_state != ST_IDLE);
  assign bus.cmd_ready = r_cmd_ready;
  assign bus.rsp_valid = (r_state == ST_DONE);
  assign bus.rsp_data  = w_rx_q;
  assign bus.rsp_err   = r_err;

endmodule

// File: tb/tb_serial_seq_ctrl.sv
// Directed bench: a negedge datapath model checks din framing and plays back
// responses; a scoreboard monitor checks every consumed response.
module tb_serial_seq_ctrl;
  localparam int DW = 8;
  localparam int RW = 8;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic abort = 1'b0;
  logic start;
  logic din;
  logic dout = 1'b0;
  logic busy;

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] cmd_q[$];
  logic [RW:0]   exp_q[$];

  logic          plan_en = 1'b0;
  int            plan_delay = 0;
  logic [RW-1:0] plan_word = '0;

  int            mdl_phase = 0;
  int            mdl_cnt = 0;
  logic [DW-1:0] mdl_cmd = '0;

  serial_seq_ctrl_if #(.DATA_W(DW), .RESP_W(RW)) bus ();

  serial_seq_ctrl #(.DATA_W(DW), .RESP_W(RW), .TIMEOUT(TO)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .i_abort (abort),
    .o_start (start),
    .o_din   (din),
    .i_dout  (dout),
    .o_busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Datapath model: checks framing of din, then drives the response on dout
  always @(negedge clk) begin
    case (mdl_phase)
      0: begin
        dout = 1'b0;
        if (start) begin
          chk("start_expected", cmd_q.size() > 0, 1);
          if (cmd_q.size() > 0) mdl_cmd = cmd_q.pop_front();
          mdl_phase = 1;
          mdl_cnt = 0;
        end
      end
      1: begin
        if (!rst_n || !busy) begin
          mdl_phase = 0;
        end else begin
          if (mdl_cnt == 0) chk("start_width", start, 0);
          chk("din_bit", din, mdl_cmd[DW-1-mdl_cnt]);
          mdl_cnt++;
          if (mdl_cnt == DW) begin
            mdl_phase = 2;
            mdl_cnt = 0;
          end
        end
      end
      2: begin
        if (!rst_n || !busy) begin
          mdl_phase = 0;
          dout = 1'b0;
        end else begin
          dout = plan_en && (mdl_cnt == plan_delay);
          if (dout) begin
            mdl_phase = 3;
            mdl_cnt = 0;
          end else begin
            mdl_cnt++;
          end
          if (bus.rsp_valid) mdl_phase = 0;
        end
      end
      3: begin
        if (!rst_n || !busy) begin
          mdl_phase = 0;
          dout = 1'b0;
        end else begin
          dout = plan_word[RW-1-mdl_cnt];
          mdl_cnt++;
          if (mdl_cnt == RW) mdl_phase = 0;
        end
      end
      default: mdl_phase = 0;
    endcase
  end

  // Scoreboard monitor: every consumed response must match the queue head
  always @(negedge clk) begin
    logic [RW:0] e;
    #2;
    if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL rsp_unexpected: got data %0h err %0b, expected none", bus.rsp_data, bus.rsp_err);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_data", bus.rsp_data, e[RW-1:0]);
        chk("rsp_err", bus.rsp_err, e[RW]);
      end
    end
  end

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_cmd_ready"}, bus.cmd_ready, 1);
    chk({tag, "_start"}, start, 0);
    chk({tag, "_din"}, din, 0);
    chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    chk({tag, "_rsp_data"}, bus.rsp_data, 0);
    chk({tag, "_rsp_err"}, bus.rsp_err, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic set_plan(input logic en, input int dly, input logic [RW-1:0] w);
    plan_en = en;
    plan_delay = dly;
    plan_word = w;
  endtask

  // Offer a command at a negedge; returns at the negedge of the START cycle
  task automatic issue(input logic [DW-1:0] cmd, input logic [RW-1:0] d_exp,
                       input logic e_exp, input bit expect_rsp);
    int n;
    cmd_q.push_back(cmd);
    if (expect_rsp) exp_q.push_back({e_exp, d_exp});
    bus.cmd_valid = 1'b1;
    bus.cmd_data = cmd;
    n = 0;
    while (!bus.cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_accept", bus.cmd_ready, 1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk("start_latency", start, 1);
  endtask

  // Wait for rsp_valid (offset counted from the START cycle), hold, consume
  task automatic wait_rsp(input int exp_lat, input logic [RW-1:0] d_exp,
                          input logic e_exp, input int hold, input bit bp_cmd);
    int n;
    n = 1;
    while (!bus.rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_latency", n, exp_lat);
    for (int i = 0; i < hold; i++) begin
      chk("bp_valid", bus.rsp_valid, 1);
      chk("bp_data", {bus.rsp_err, bus.rsp_data}, {e_exp, d_exp});
      if (bp_cmd) chk("bp_no_accept", bus.cmd_ready, 0);
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("rsp_pulse", bus.rsp_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seen;
    bus.cmd_valid = 1'b0;
    bus.cmd_data = '0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle_outputs("post_reset");

    // Basic transfer: start bit in first WAIT cycle
    set_plan(1'b1, 0, 8'h3C);
    issue(8'hA5, 8'h3C, 1'b0, 1'b1);
    wait_rsp(19, 8'h3C, 1'b0, 0, 1'b0);
    chk("idle_after_rsp", busy, 0);

    // Timeout with dout held low: WAIT lasts 16 cycles
    set_plan(1'b0, 0, 8'h00);
    issue(8'h3C, 8'h00, 1'b1, 1'b1);
    wait_rsp(26, 8'h00, 1'b1, 0, 1'b0);

    // Start bit on the 16th (last) WAIT cycle still captures
    set_plan(1'b1, 15, 8'h96);
    issue(8'h81, 8'h96, 1'b0, 1'b1);
    wait_rsp(34, 8'h96, 1'b0, 0, 1'b0);

    // Start bit on the 17th cycle is too late
    set_plan(1'b1, 16, 8'hE7);
    issue(8'h7E, 8'h00, 1'b1, 1'b1);
    wait_rsp(26, 8'h00, 1'b1, 0, 1'b0);

    // Backpressure with a command pending during DONE
    set_plan(1'b1, 2, 8'h69);
    issue(8'h0F, 8'h69, 1'b0, 1'b1);
    cmd_q.push_back(8'h5A);
    exp_q.push_back({1'b0, 8'hC3});
    bus.cmd_valid = 1'b1;
    bus.cmd_data = 8'h5A;
    wait_rsp(21, 8'h69, 1'b0, 5, 1'b1);
    set_plan(1'b1, 0, 8'hC3);
    chk("bp_ready_after_hs", bus.cmd_ready, 1);
    chk("bp_busy_after_hs", busy, 0);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk("bp_late_accept", start, 1);
    wait_rsp(19, 8'hC3, 1'b0, 0, 1'b0);

    // Abort while din carries command bit 3
    set_plan(1'b1, 0, 8'h11);
    issue(8'hC3, 8'h00, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_din", din, 0);
    chk("abort_cmd_ready", bus.cmd_ready, 1);
    chk("abort_start", start, 0);
    bus.rsp_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      if (bus.rsp_valid) seen++;
      @(negedge clk);
    end
    bus.rsp_ready = 1'b0;
    chk("abort_no_rsp", seen, 0);
    set_plan(1'b1, 1, 8'h5A);
    issue(8'hFF, 8'h5A, 1'b0, 1'b1);
    wait_rsp(20, 8'h5A, 1'b0, 0, 1'b0);

    // Asynchronous reset in the middle of CAPT
    set_plan(1'b1, 0, 8'hAA);
    issue(8'h77, 8'hAA, 1'b0, 1'b1);
    repeat (12) @(negedge clk);
    chk("capt_busy", busy, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("async_reset");
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    set_plan(1'b1, 0, 8'h80);
    issue(8'h01, 8'h80, 1'b0, 1'b1);
    wait_rsp(19, 8'h80, 1'b0, 0, 1'b0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("cmd_queue_empty", cmd_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_seq_ctrl.md
# serial_seq_ctrl

Sequencer for a bit-serial start/din/dout datapath. Accepts a parallel command word over a valid/ready handshake, frames it as a one-cycle `start` pulse followed by DATA_W serial bits on `din`, then waits a bounded time for the datapath's serial response on `dout`. It captures RESP_W response bits and returns them, with an error flag, over a second valid/ready handshake. It sits between a register or command front-end and one serial datapath instance.

## Interface
- DATA_W, 8: command bits shifted out per transaction (≥1)
- RESP_W, 8: response bits captured per transaction (≥1)
- TIMEOUT, 16: max cycles in WAIT for the response start bit (≥1)

- clk  input  1  single clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- cmd_valid  input  1  command offered
- cmd_ready  output  1  controller can accept a command
- cmd_data  input  DATA_W  command word, shifted MSB-first
- abort  input  1  synchronous abort of the current transaction
- start  output  1  one-cycle frame-start pulse to the datapath
- din  output  1  serial command bit to the datapath
- dout  input  1  serial response from the datapath
- rsp_valid  output  1  response available
- rsp_ready  input  1  consumer accepts response
- rsp_data  output  RESP_W  captured response, first bit received in MSB
- rsp_err  output  1  timeout; rsp_data is all-zero when set
- busy  output  1  high in every state except IDLE

## Operation
- States: IDLE, START, SHIFT, WAIT, CAPT, DONE.
- IDLE: cmd_ready=1. When cmd_valid&cmd_ready, latch cmd_data into the TX shift register, clear rsp_data and rsp_err, go to START.
- START: start=1, din=0, one cycle, then SHIFT with the bit counter at 0.
- SHIFT: din = TX register MSB; the register shifts left each cycle. After DATA_W cycles, go to WAIT with the timeout counter at 0.
- WAIT: sample dout every cycle.
  - dout=1 is the response start bit (not captured): go to CAPT.
  - The counter reaches TIMEOUT-1 with dout=0: go to DONE with rsp_err=1.
- CAPT: shift dout into the LSB of the RX register for RESP_W cycles, then go to DONE.
- DONE: rsp_valid=1. rsp_data and rsp_err stay stable until rsp_valid&rsp_ready, then go to IDLE. A new command can be accepted no earlier than the cycle after the handshake.
- abort: when sampled high in any state other than IDLE, next state is IDLE. No rsp_valid is produced, and start and din are 0 from the next cycle. In IDLE, abort is ignored. Abort has priority over every other transition, including the DONE handshake in the same cycle; in that case the response counts as consumed.
- Counters are sized $clog2(max(DATA_W,RESP_W,TIMEOUT)+1) and never wrap inside a state.
- start, din and cmd_ready are registered outputs. dout is sampled only in WAIT and CAPT.

## Timing
- Reset (async assert, sync deassert handled upstream): state=IDLE. Outputs after reset: cmd_ready=1, start=0, din=0, rsp_valid=0, rsp_data=0, rsp_err=0, busy=0.
- Command accepted at edge T:
  - start high in cycle T+1.
  - din carries bit DATA_W-1..0 in cycles T+2..T+1+DATA_W.
  - WAIT begins in cycle T+2+DATA_W.
- Response start bit seen in WAIT cycle W: response bits sampled in cycles W+1..W+RESP_W; rsp_valid rises in W+RESP_W+1.
- Timeout: WAIT lasts exactly TIMEOUT cycles; rsp_valid with rsp_err=1 is asserted in the following cycle.
- Minimum transaction, accept to rsp_valid: 1+DATA_W+1+RESP_W+1 cycles (response start bit in the first WAIT cycle).
- cmd_valid held while busy: no acceptance; cmd_ready=0.
- rsp_ready held high in DONE: single-cycle rsp_valid pulse.

## Structure
- Package serial_seq_pkg contains:
  - the state enum (state_t) and its encodings;
  - a function for the counter width;
  - default parameter constants.
- One sub-module: serial_shreg, a generic width-parameterised shift register with load, shift-in bit, MSB out and clear. It is instantiated twice, for TX and RX.
- The FSM, counters and handshake logic stay in serial_seq_ctrl.

## Test plan
- Basic transfer (DATA_W=8, RESP_W=8, TIMEOUT=16), cmd_data=8'hA5, datapath model returns start bit then 8'h3C:
  - din shows 1,0,1,0,0,1,0,1 after the single start pulse;
  - rsp_data=8'h3C, rsp_err=0.
- Timeout, dout held 0: WAIT lasts 16 cycles, then rsp_valid=1, rsp_err=1, rsp_data=0.
- Response start bit on the 16th and last WAIT cycle: capture succeeds (rsp_err=0). Start bit on cycle 17: timeout.
- Backpressure, rsp_ready low for 5 cycles in DONE:
  - rsp_valid and rsp_data stay stable;
  - a cmd_valid asserted during DONE is not accepted until the cycle after the handshake.
- Abort asserted mid-SHIFT (bit 3): next cycle state=IDLE, din=0, cmd_ready=1, no rsp_valid. A following cmd 8'hFF completes normally.
- rst_n asserted mid-CAPT: all outputs take reset values immediately (asynchronously). After release, cmd 8'h01 completes normally with a response of 8'h80.
